// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, constants and baud helper for the TX/RX blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_drain_if.sv
// ============================================================================
// Module : uart_tx_fifo_drain_if
// Brief  : Byte FIFO read port between the TX FIFO and the UART drain.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_fifo_drain_if;
    import uart_pkg::*;

    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_rd_en;

    // master issues pops, slave is the FIFO itself
    modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);

endinterface

`default_nettype wire

// File: rtl/baud_counter.sv
// ============================================================================
// Module : baud_counter
// Brief  : Per-symbol cycle counter; pulses o_bit_done on the last cycle of a bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module baud_counter #(
    parameter int SYMBOL_EDGE_TIME = 10,
    parameter int COUNT_WIDTH      = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_run,
    output logic      o_bit_done
);

    localparam logic [COUNT_WIDTH-1:0] c_last = COUNT_WIDTH'(SYMBOL_EDGE_TIME - 1);

    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_at_last;

    assign w_at_last  = (r_count == c_last);
    assign o_bit_done = i_run && w_at_last;

    // Only ever returns to zero through an explicit clear, never by overflow.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    a_symbol_time_min: assert property (@(posedge clk) SYMBOL_EDGE_TIME >= 2);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
// ============================================================================
// Module : uart_tx_fifo_drain
// Brief  : Pops bytes from the TX FIFO and sends each as an 8N1 UART frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              enable,
    uart_tx_fifo_drain_if.master   fifo,
    output logic                   serial_out,
    output logic                   busy
);

    localparam int SYMBOL_EDGE_TIME    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CLOCK_COUNTER_WIDTH = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int BIT_IDX_WIDTH       = $clog2(UART_DATA_BITS);
    localparam logic [BIT_IDX_WIDTH-1:0] c_last_bit = BIT_IDX_WIDTH'(UART_DATA_BITS - 1);

    uart_state_e                r_state;
    uart_state_e                w_state_next;
    logic [UART_DATA_BITS-1:0]  r_shift;
    logic [UART_DATA_BITS-1:0]  w_shift_next;
    logic [BIT_IDX_WIDTH-1:0]   r_bit_idx;
    logic [BIT_IDX_WIDTH-1:0]   w_bit_idx_next;
    logic                       r_serial;
    logic                       w_serial_next;
    logic                       w_rd_en;
    logic                       w_cnt_clear;
    logic                       w_cnt_run;
    logic                       w_bit_done;

    baud_counter #(
        .SYMBOL_EDGE_TIME (SYMBOL_EDGE_TIME),
        .COUNT_WIDTH      (CLOCK_COUNTER_WIDTH)
    ) u_baud_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clear),
        .i_run      (w_cnt_run),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_serial  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_serial  <= w_serial_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_rd_en        = 1'b0;
        w_cnt_clear    = 1'b0;
        w_cnt_run      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clear = 1'b1;
                if (!rst && enable && !fifo.fifo_empty) begin
                    w_rd_en      = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // FIFO read data is valid the cycle after the pop strobe.
                w_cnt_clear  = 1'b1;
                w_shift_next = fifo.fifo_dout;
                w_state_next = ST_START;
            end
            ST_START: begin
                w_cnt_run = 1'b1;
                if (w_bit_done) begin
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                w_cnt_run = 1'b1;
                if (w_bit_done) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == c_last_bit) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                w_cnt_run = 1'b1;
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level is decided from the upcoming state so the registered pin lines up with it.
    always_comb begin
        w_serial_next = 1'b1;
        case (w_state_next)
            ST_START: w_serial_next = 1'b0;
            ST_DATA:  w_serial_next = w_shift_next[0];
            default:  w_serial_next = 1'b1;
        endcase
    end

    assign fifo.fifo_rd_en = w_rd_en;
    assign serial_out      = r_serial;
    assign busy            = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
// ============================================================================
// Module : tb_uart_tx_fifo_drain
// Brief  : Directed, table-driven bench for the UART TX FIFO drain (10 clk/bit).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo_drain;

    logic clk;
    logic rst;
    logic enable;
    logic serial_out;
    logic busy;

    uart_tx_fifo_drain_if bus ();

    uart_tx_fifo_drain #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo       (bus.master),
        .serial_out (serial_out),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte FIFO model: bench pushes, pops happen on the strobe.
    logic [7:0] mem [0:63];
    int n_pushed = 0;
    int n_popped = 0;

    assign bus.fifo_empty = (n_pushed == n_popped);

    always @(posedge clk) begin
        if (bus.fifo_rd_en === 1'b1) begin
            bus.fifo_dout <= mem[n_popped[5:0]];
            n_popped      <= n_popped + 1;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // [0]=start, [8:1]=data LSB first, [9]=stop
    } vec_t;

    vec_t tbl [0:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[n_pushed[5:0]] = b;
        n_pushed = n_pushed + 1;
    endtask

    task automatic wait_pop(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.fifo_rd_en === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, " pop_seen"}, 32'(got), 32'd1);
    endtask

    // Entered on the sample point where the pop strobe is high.
    task automatic check_frame(input logic [9:0] line, input string name);
        chk({name, " rd_en_pulse"}, 32'(bus.fifo_rd_en), 32'd1);
        step();
        chk({name, " fetch_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
        chk({name, " fetch_line"}, 32'(serial_out), 32'd1);
        chk({name, " fetch_busy"}, 32'(busy), 32'd1);
        for (int b = 0; b < 10; b++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (serial_out !== line[b]) bad++;
            end
            chk($sformatf("%s bit%0d bad_cycles", name, b), 32'(bad), 32'd0);
        end
        chk({name, " busy_last_stop"}, 32'(busy), 32'd1);
        step();
        chk({name, " busy_after_102"}, 32'(busy), 32'd0);
        chk({name, " line_idle"}, 32'(serial_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        int seen_pop;
        int seen_low;
        int seen_busy;

        tbl[0] = '{data: 8'h5A, line: 10'b1_01011010_0};
        tbl[1] = '{data: 8'h01, line: 10'b1_00000001_0};
        tbl[2] = '{data: 8'h80, line: 10'b1_10000000_0};
        tbl[3] = '{data: 8'hC3, line: 10'b1_11000011_0};

        // Reset held with FIFO non-empty and enable high.
        rst    = 1'b1;
        enable = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset%0d line", i), 32'(serial_out), 32'd1);
            chk($sformatf("reset%0d rd_en", i), 32'(bus.fifo_rd_en), 32'd0);
            chk($sformatf("reset%0d busy", i), 32'(busy), 32'd0);
        end
        rst = 1'b0;

        wait_pop("A5");
        check_frame(10'b1_10100101_0, "A5");
        chk("A5 pop_count", 32'(n_popped), 32'd1);

        for (int v = 0; v < 4; v++) begin
            push(tbl[v].data);
            wait_pop($sformatf("tbl%0d", v));
            check_frame(tbl[v].line, $sformatf("tbl%0d", v));
            chk($sformatf("tbl%0d pop_count", v), 32'(n_popped), 32'(n_pushed));
        end

        // Back-to-back: gap is the IDLE + FETCH cycles checked at the frame seam.
        pops0 = n_popped;
        push(8'h00);
        push(8'hFF);
        wait_pop("b2b");
        check_frame(10'b1_00000000_0, "b2b_00");
        check_frame(10'b1_11111111_0, "b2b_FF");
        repeat (10) step();
        chk("b2b pops", 32'(n_popped - pops0), 32'd2);

        // Empty FIFO with enable high.
        seen_pop  = 0;
        seen_busy = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.fifo_rd_en !== 1'b0) seen_pop++;
            if (busy !== 1'b0) seen_busy++;
        end
        chk("empty rd_en_cycles", 32'(seen_pop), 32'd0);
        chk("empty busy_cycles", 32'(seen_busy), 32'd0);

        // Enable low with data waiting.
        enable = 1'b0;
        push(8'h3C);
        pops0    = n_popped;
        seen_pop = 0;
        seen_low = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.fifo_rd_en !== 1'b0) seen_pop++;
            if (serial_out !== 1'b1) seen_low++;
        end
        chk("gate rd_en_cycles", 32'(seen_pop), 32'd0);
        chk("gate line_low_cycles", 32'(seen_low), 32'd0);
        chk("gate pops", 32'(n_popped - pops0), 32'd0);

        // Enable dropped mid-frame; a second byte waits behind it.
        enable = 1'b1;
        wait_pop("3C");
        push(8'h99);
        fork
            check_frame(10'b1_00111100_0, "3C");
            begin
                repeat (40) step();
                enable = 1'b0;
            end
        join
        chk("3C rd_en_after", 32'(bus.fifo_rd_en), 32'd0);
        pops0     = n_popped;
        seen_pop  = 0;
        seen_busy = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.fifo_rd_en !== 1'b0) seen_pop++;
            if (busy !== 1'b0) seen_busy++;
        end
        chk("hold rd_en_cycles", 32'(seen_pop), 32'd0);
        chk("hold busy_cycles", 32'(seen_busy), 32'd0);
        chk("hold pops", 32'(n_popped - pops0), 32'd0);
        enable = 1'b1;
        wait_pop("99");
        check_frame(10'b1_10011001_0, "99");

        // Reset during data bit 3 of 0x81; 0x42 follows, 0x81 must not repeat.
        push(8'h81);
        push(8'h42);
        wait_pop("81");
        repeat (45) step();
        chk("81 bit3_level", 32'(serial_out), 32'd0);
        chk("81 busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst line", 32'(serial_out), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst = 1'b0;
        wait_pop("42");
        check_frame(10'b1_01000010_0, "42");
        repeat (20) step();
        chk("midrst pops", 32'(n_popped), 32'(n_pushed));
        chk("midrst idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Downstream consumer of the I/O-circuit byte FIFO: pops bytes from the FIFO read port and serializes each one onto the UART TX line (8N1, LSB first).
Sits between the TX FIFO and the board serial pin, so the CPU side only writes the FIFO and never waits on baud timing.
Throughput is one frame per byte plus a fixed 2-cycle inter-frame gap.

Parameters:
CLOCK_FREQ, 125_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate in bits/s
SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE (integer divide), clock cycles per serial bit
CLOCK_COUNTER_WIDTH, $clog2(SYMBOL_EDGE_TIME), width of the baud counter

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous and active-high
enable  input  1  permits the start of a new frame; a frame in progress always completes
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  8  FIFO read data; valid the cycle after fifo_rd_en is asserted
fifo_rd_en  output  1  FIFO pop strobe, one cycle per byte
serial_out  output  1  UART TX line; idles high
busy  output  1  high whenever state != IDLE

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst, and all state is cleared on the rising edge with rst=1.
- Reset values:
  - state=IDLE
  - serial_out=1 (registered output)
  - busy=0
  - fifo_rd_en=0
  - baud counter=0, bit index=0, shift register=0
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - fifo_rd_en = (state==IDLE) && enable && !fifo_empty, combinational. It is never asserted when fifo_empty=1.
  - When fifo_rd_en=1, the next state is FETCH. Otherwise the block stays in IDLE.
- FETCH (exactly 1 cycle):
  - Capture fifo_dout into the 8-bit shift register.
  - Next state START, with the baud counter cleared.
- START:
  - serial_out=0 for SYMBOL_EDGE_TIME cycles.
  - When the counter reaches SYMBOL_EDGE_TIME-1, clear the counter and go to DATA with bit index 0.
- DATA:
  - serial_out=shift_reg[0] for SYMBOL_EDGE_TIME cycles per bit.
  - At the end of each bit: shift the register right, increment the bit index, clear the counter.
  - After bit index 7 completes, go to STOP.
- STOP:
  - serial_out=1 for SYMBOL_EDGE_TIME cycles, then go to IDLE.
- Timing:
  - The start bit's falling edge appears on serial_out 2 cycles after the fifo_rd_en cycle, because serial_out is registered.
  - Back-to-back bytes: the frame ends, then 1 IDLE cycle plus 1 FETCH cycle of line-high, then the next start bit. The line stays high during the gap.
- enable:
  - enable is sampled only in IDLE.
  - Deasserting enable mid-frame has no effect; the current frame completes, then the block holds in IDLE.
- fifo_empty rising mid-frame: no effect. It is only evaluated in IDLE.
- Reset mid-frame:
  - serial_out returns to 1 on the reset edge, and the frame is aborted.
  - The already-popped byte is discarded and is not re-read.
- The baud counter wraps only via explicit clear, never by overflow.
- SYMBOL_EDGE_TIME must be >= 2; this is enforced by a simulation-time assertion.
- busy = (state != IDLE). It is 1 from FETCH through the last STOP cycle inclusive.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, FETCH, START, DATA, STOP)
  - UART_DATA_BITS=8
  - the SYMBOL_EDGE_TIME computation function
- One natural sub-module: baud_counter.
  - Inputs: clear, run.
  - Output: bit_done, a 1-cycle pulse at count SYMBOL_EDGE_TIME-1.
  - Reused by the future uart_rx side.
- The shift register and FSM stay in the top module.

Test Plan:
All scenarios run with CLOCK_FREQ=1000 and BAUD_RATE=100, so SYMBOL_EDGE_TIME=10.
- Reset: hold rst=1 for 3 cycles, with FIFO non-empty and enable=1 -> serial_out=1, fifo_rd_en=0, busy=0 throughout.
- Single byte 0xA5:
  - Stimulus: enable=1, fifo_empty falls.
  - Required: fifo_rd_en high for exactly 1 cycle.
  - Required: start bit begins 2 cycles later.
  - Required: line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each held exactly 10 cycles.
  - Required: busy falls after 102 cycles.
- Back-to-back 0x00 then 0xFF (FIFO holds two entries):
  - Required: exactly 2 line-high cycles between the end of the first stop bit and the second start bit.
  - Required: exactly two fifo_rd_en pulses.
- enable gating:
  - Stimulus: enable=0 with the FIFO non-empty for 50 cycles.
  - Required: no pop and serial_out=1 throughout.
  - Stimulus: drop enable mid-way through a frame of 0x3C.
  - Required: the frame completes intact and no further pop occurs.
- Empty FIFO: fifo_empty=1 for 100 cycles with enable=1 -> fifo_rd_en never asserted, busy=0.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3 of 0x81.
  - Required: serial_out=1 on the next edge, state IDLE.
  - Required: after release, the next FIFO byte (0x42) is sent correctly and 0x81 is not resent.
